lfsr_arbiter: RTL
=================

# lfsr_arbiter

Round-robin scheduler that owns a 16-bit Fibonacci LFSR and shares its pseudo-random stream among NREQ requesters in the NeuralNetwork F_node datapath, such as weight-init and dropout units. The LFSR holds no value until a seed is loaded. After that, each granted requester receives a fixed-length burst of consecutive LFSR words, and the LFSR advances exactly once per delivered word. Every requester therefore gets a disjoint, reproducible slice of the sequence.

## Interface
- NREQ, 4: number of requesters, from 2 to 8.
- BURST_LEN, 4: words delivered per grant, from 1 to 255.
- clk  in  1  system clock; all logic is on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- seed  in  16  seed value, sampled when seed_load=1.
- seed_load  in  1  single-cycle pulse that loads seed into the LFSR.
- req  in  NREQ  per-requester request level, held until the requester is granted.
- grant  out  NREQ  one-hot grant, high for every cycle of the burst.
- rnd_valid  out  1  high when rnd_data carries a word for the granted requester.
- rnd_data  out  16  LFSR word being delivered.
- busy  out  1  high while in state BURST.
- served_cnt  out  16  count of delivered words; only functional with LFSR_ARB_STATS_EN.

## Operation
- LFSR step, next state:
  - fb = q[15]^q[13]^q[12]^q[10]
  - q_next = {q[14:0], fb}
- Seeding:
  - seed=0 is replaced with 16'h0001 to avoid lock-up.
- States: UNSEEDED, IDLE, BURST.
- UNSEEDED:
  - req is ignored and no grants are issued.
  - seed_load loads the LFSR and moves to IDLE.
- IDLE:
  - If any req bit is set, select the first set bit at or after the priority pointer ptr, wrapping modulo NREQ.
  - Move to BURST with burst counter bcnt=0.
- BURST:
  - Each cycle: grant=onehot(k), rnd_valid=1, rnd_data=q. The LFSR steps and bcnt increments.
  - When bcnt=BURST_LEN-1, return to IDLE and set ptr=(k+1) mod NREQ.
  - Changes on req during a burst are ignored; the burst always runs to completion.
- seed_load in IDLE or BURST:
  - Has priority over everything else.
  - Aborts any burst: grant and rnd_valid are 0 on the next cycle.
  - Loads the LFSR and moves to IDLE. ptr is unchanged.
- Reset values:
  - State UNSEEDED, q=16'h0001, ptr=0, bcnt=0.
  - grant=0, rnd_valid=0, rnd_data=0, busy=0, served_cnt=0.
- Reset is asynchronous and can occur mid-burst. Outputs clear immediately, and no partial-burst state survives.
- All outputs are registered.

## Timing
- A request sampled high at edge t in IDLE produces grant/rnd_valid/first word at edge t+1.
- The burst occupies exactly BURST_LEN consecutive cycles.
- There is a one-cycle IDLE bubble between back-to-back bursts. Peak throughput is BURST_LEN/(BURST_LEN+1) words per cycle.
- seed_load at edge t: the new q is visible as rnd_data of the first word of the next burst, at the earliest edge t+2.
- The LFSR advances only on cycles with rnd_valid=1. Idle cycles do not consume the sequence.
- A requester whose req is high in IDLE waits at most (NREQ-1)·(BURST_LEN+1) cycles before its grant.

## Configuration
- LFSR_ARB_STATS_EN defined:
  - served_cnt increments on every cycle with rnd_valid=1 and wraps from 16'hFFFF to 0.
  - It is not cleared by seed_load; only resetn clears it.
- LFSR_ARB_STATS_EN undefined:
  - served_cnt is the constant 0 and the counter logic is not built.

## Test plan
- Requests before seeding:
  - Stimulus: reset, then req=4'b1111 with no seed_load for 20 cycles.
  - Required: grant=0 and rnd_valid=0 throughout.
- Seeded single requester:
  - Stimulus: seed=1, seed_load, then req[0]=1.
  - Required: rnd_data = 0x0001, 0x0002, 0x0004, 0x0008 with grant=4'b0001, then one idle cycle.
- Seed of zero:
  - Stimulus: seed=0, seed_load, then req[2]=1.
  - Required: first word 0x0001.
- All-ones seed:
  - Stimulus: seed=0xFFFF.
  - Required: words 0xFFFF, 0xFFFE, …
- Round robin:
  - Stimulus: req=4'b1111 held, starting with ptr=0.
  - Required: grants in order 0001, 0010, 0100, 1000, 0001.
  - Required: words are contiguous across requesters, with no repeats and no skips versus a reference LFSR model.
- Abort:
  - Stimulus: seed_load=1 with seed=0x00AA on the 2nd cycle of a burst.
  - Required: grant drops the next cycle, and the next burst starts with 0x00AA.
  - Required: with LFSR_ARB_STATS_EN, served_cnt=2.
- Asynchronous reset mid-burst:
  - Required: outputs clear without a clock edge, state is UNSEEDED, and served_cnt=0.

Source files
------------

// File: rtl/lfsr_arbiter.sv
// lfsr_arbiter: round-robin owner of a 16-bit Fibonacci LFSR.
// Each granted requester receives BURST_LEN consecutive LFSR words, so every
// requester consumes a disjoint, reproducible slice of the sequence. The
// LFSR only advances on delivered words.
//
// Optional feature: define LFSR_ARB_STATS_EN to build the 16-bit delivered
// word counter on served_cnt. Without it served_cnt is tied to zero.
module lfsr_arbiter #(
  parameter int NREQ      = 4,
  parameter int BURST_LEN = 4
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [15:0]     seed,
  input  logic            seed_load,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] grant,
  output logic            rnd_valid,
  output logic [15:0]     rnd_data,
  output logic            busy,
  output logic [15:0]     served_cnt
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [7:0] BCNT_LAST = 8'(BURST_LEN - 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(NREQ - 1);

  typedef enum logic [1:0] {
    ST_UNSEEDED = 2'd0,
    ST_IDLE     = 2'd1,
    ST_BURST    = 2'd2
  } state_e;

  // ---------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------

  // One Fibonacci step, taps 16/14/13/11 (bits 15,13,12,10).
  function automatic logic [15:0] lfsr_step(input logic [15:0] q);
    logic fb;
    fb = q[15] ^ q[13] ^ q[12] ^ q[10];
    return {q[14:0], fb};
  endfunction

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  function automatic logic [15:0] seed_fix(input logic [15:0] s);
    return (s == 16'h0000) ? 16'h0001 : s;
  endfunction

  // First set request at or after the pointer, wrapping modulo NREQ.
  function automatic logic [PW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                            input logic [PW-1:0]   p);
    logic [PW-1:0] res;
    logic          found;
    int            sum;
    int            idx;
    res   = p;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      sum = int'(p) + i;
      idx = (sum >= NREQ) ? (sum - NREQ) : sum;
      if (!found && r[PW'(idx)]) begin
        res   = PW'(idx);
        found = 1'b1;
      end
    end
    return res;
  endfunction

  // Decode a requester index into a one-hot grant vector.
  function automatic logic [NREQ-1:0] onehot(input logic [PW-1:0] k);
    logic [NREQ-1:0] v;
    v = {NREQ{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      if (PW'(i) == k) begin
        v[i] = 1'b1;
      end
    end
    return v;
  endfunction

  // Priority pointer moves one past the requester just served.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] k);
    return (k == PTR_LAST) ? {PW{1'b0}} : (k + PW'(1));
  endfunction

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  state_e          state_q,     state_d;
  logic [15:0]     lfsr_q,      lfsr_d;
  logic [PW-1:0]   ptr_q,       ptr_d;
  logic [PW-1:0]   sel_q,       sel_d;
  logic [7:0]      bcnt_q,      bcnt_d;
  logic [NREQ-1:0] grant_q,     grant_d;
  logic            rnd_valid_q, rnd_valid_d;
  logic [15:0]     rnd_data_q,  rnd_data_d;
  logic            busy_q,      busy_d;

  // Next-state, LFSR and output computation; seed_load overrides all.
  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    ptr_d       = ptr_q;
    sel_d       = sel_q;
    bcnt_d      = bcnt_q;
    grant_d     = {NREQ{1'b0}};
    rnd_valid_d = 1'b0;
    rnd_data_d  = 16'h0000;

    if (seed_load) begin
      // Abort any burst; the pointer is kept so fairness is preserved.
      lfsr_d  = seed_fix(seed);
      state_d = ST_IDLE;
      bcnt_d  = 8'd0;
    end else begin
      case (state_q)
        ST_UNSEEDED: begin
          state_d = ST_UNSEEDED;
        end
        ST_IDLE: begin
          if (|req) begin
            sel_d   = rr_pick(req, ptr_q);
            bcnt_d  = 8'd0;
            state_d = ST_BURST;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_BURST: begin
          // req is ignored here: a burst always runs to completion.
          grant_d     = onehot(sel_q);
          rnd_valid_d = 1'b1;
          rnd_data_d  = lfsr_q;
          lfsr_d      = lfsr_step(lfsr_q);
          if (bcnt_q == BCNT_LAST) begin
            state_d = ST_IDLE;
            bcnt_d  = 8'd0;
            ptr_d   = ptr_inc(sel_q);
          end else begin
            bcnt_d  = bcnt_q + 8'd1;
          end
        end
        default: begin
          state_d = ST_UNSEEDED;
        end
      endcase
    end

    busy_d = (state_d == ST_BURST);
  end

  // Registered FSM state and outputs with asynchronous clear.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_UNSEEDED;
      lfsr_q      <= 16'h0001;
      ptr_q       <= {PW{1'b0}};
      sel_q       <= {PW{1'b0}};
      bcnt_q      <= 8'd0;
      grant_q     <= {NREQ{1'b0}};
      rnd_valid_q <= 1'b0;
      rnd_data_q  <= 16'h0000;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      ptr_q       <= ptr_d;
      sel_q       <= sel_d;
      bcnt_q      <= bcnt_d;
      grant_q     <= grant_d;
      rnd_valid_q <= rnd_valid_d;
      rnd_data_q  <= rnd_data_d;
      busy_q      <= busy_d;
    end
  end

  assign grant     = grant_q;
  assign rnd_valid = rnd_valid_q;
  assign rnd_data  = rnd_data_q;
  assign busy      = busy_q;

`ifdef LFSR_ARB_STATS_EN
  logic [15:0] served_cnt_q, served_cnt_d;

  // Count every delivered word; wraps naturally, survives seed_load.
  always_comb begin
    if (rnd_valid_d) begin
      served_cnt_d = served_cnt_q + 16'd1;
    end else begin
      served_cnt_d = served_cnt_q;
    end
  end

  // Delivered-word counter register, cleared only by resetn.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      served_cnt_q <= 16'h0000;
    end else begin
      served_cnt_q <= served_cnt_d;
    end
  end

  assign served_cnt = served_cnt_q;
`else
  assign served_cnt = 16'h0000;
`endif

endmodule
